// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared constants, state encoding and point type for the laser coverage blocks
package laser_pkg;
  localparam int N_POINTS  = 40;
  localparam int RADIUS_SQ = 16;
  localparam int COORD_W   = 4;
  localparam int IDX_W     = 6;
  localparam int TIMEOUT   = 4095;
  localparam int WAIT_W    = 12;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

  typedef enum logic [2:0] {IDLE, ARM, STREAM, WAIT_RES, SCORE, REPORT} state_t;

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a > b) ? coord_t'(a - b) : coord_t'(b - a);
  endfunction
endpackage

// File: rtl/laser_cover_chk.sv
// rtl/laser_cover_chk.sv - covered bit: point lies within the coverage radius of either centre
module laser_cover_chk
  import laser_pkg::*;
(
  input  logic [COORD_W-1:0] px,
  input  logic [COORD_W-1:0] py,
  input  logic [COORD_W-1:0] c1x,
  input  logic [COORD_W-1:0] c1y,
  input  logic [COORD_W-1:0] c2x,
  input  logic [COORD_W-1:0] c2y,
  output logic               covered
);
  logic [8:0] dx1, dy1, dx2, dy2, d1, d2;

  // 9-bit sums: worst case 15*15 + 15*15 = 450
  always_comb begin
    dx1 = {5'd0, abs_diff(px, c1x)};
    dy1 = {5'd0, abs_diff(py, c1y)};
    dx2 = {5'd0, abs_diff(px, c2x)};
    dy2 = {5'd0, abs_diff(py, c2y)};
    d1  = dx1 * dx1 + dy1 * dy1;
    d2  = dx2 * dx2 + dy2 * dy2;
    covered = (d1 <= 9'(RADIUS_SQ)) || (d2 <= 9'(RADIUS_SQ));
  end
endmodule

// File: rtl/laser_host_driver.sv
// rtl/laser_host_driver.sv - image store, point streamer, result capture and coverage scorer for the laser solver
module laser_host_driver
  import laser_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               ld_en,
  input  logic [IDX_W-1:0]   ld_addr,
  input  logic [COORD_W-1:0] ld_x,
  input  logic [COORD_W-1:0] ld_y,
  input  logic               start,
  output logic               busy,
  output logic [COORD_W-1:0] X,
  output logic [COORD_W-1:0] Y,
  input  logic               DONE,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  output logic [COORD_W-1:0] res_c1x,
  output logic [COORD_W-1:0] res_c1y,
  output logic [COORD_W-1:0] res_c2x,
  output logic [COORD_W-1:0] res_c2y,
  output logic [IDX_W-1:0]   score,
  output logic               res_valid,
  output logic               timeout
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [IDX_W-1:0]    nxt_idx;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                seen_low;
  logic                covered;
  point_t              mem [N_POINTS];
  point_t              cur_pt;
  point_t              nxt_pt;

  assign nxt_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;
  assign cur_pt  = mem[idx];
  assign nxt_pt  = mem[nxt_idx];

  // Image memory is deliberately left out of reset
  always_ff @(posedge CLK) begin
    if (!RST && state == IDLE && ld_en && ld_addr < IDX_W'(N_POINTS))
      mem[ld_addr] <= '{x: ld_x, y: ld_y};
  end

  laser_cover_chk u_cover_chk (
    .px      (cur_pt.x),
    .py      (cur_pt.y),
    .c1x     (res_c1x),
    .c1y     (res_c1y),
    .c2x     (res_c2x),
    .c2y     (res_c2y),
    .covered (covered)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      seen_low  <= 1'b0;
      busy      <= 1'b0;
      X         <= '0;
      Y         <= '0;
      res_c1x   <= '0;
      res_c1y   <= '0;
      res_c2x   <= '0;
      res_c2y   <= '0;
      score     <= '0;
      res_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy    <= 1'b1;
          timeout <= 1'b0;
          score   <= '0;
          res_c1x <= '0;
          res_c1y <= '0;
          res_c2x <= '0;
          res_c2y <= '0;
          state   <= ARM;
        end
        ARM: if (DONE) begin
          X     <= mem[0].x;
          Y     <= mem[0].y;
          idx   <= '0;
          state <= STREAM;
        end
        STREAM: begin
          if (idx == LAST_IDX) begin
            X        <= '0;
            Y        <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            seen_low <= 1'b0;
            state    <= WAIT_RES;
          end else begin
            idx <= nxt_idx;
            X   <= nxt_pt.x;
            Y   <= nxt_pt.y;
          end
        end
        // A result only counts once the solver has been seen busy (DONE low)
        WAIT_RES: begin
          if (seen_low && DONE) begin
            res_c1x <= C1X;
            res_c1y <= C1Y;
            res_c2x <= C2X;
            res_c2y <= C2Y;
            idx     <= '0;
            state   <= SCORE;
          end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
            timeout   <= 1'b1;
            score     <= '0;
            res_c1x   <= '0;
            res_c1y   <= '0;
            res_c2x   <= '0;
            res_c2y   <= '0;
            res_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (!DONE) seen_low <= 1'b1;
          end
        end
        SCORE: begin
          if (covered) score <= score + 1'b1;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            res_valid <= 1'b1;
            state     <= REPORT;
          end else begin
            idx <= nxt_idx;
          end
        end
        REPORT: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_laser_host_driver.sv
// tb/tb_laser_host_driver.sv - randomized self-checking bench for laser_host_driver against a point-list model
module tb_laser_host_driver;
  localparam int NP = 40;
  localparam int TO_CYC = 4095;
  localparam int M_NORM = 0, M_HELD = 1, M_TO = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ld_en = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [3:0] ld_x = '0, ld_y = '0;
  logic       start = 1'b0;
  logic       DONE = 1'b0;
  logic [3:0] C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic       busy, res_valid, timeout;
  logic [3:0] X, Y, res_c1x, res_c1y, res_c2x, res_c2y;
  logic [5:0] score;

  laser_host_driver dut (
    .CLK(CLK), .RST(RST), .ld_en(ld_en), .ld_addr(ld_addr), .ld_x(ld_x), .ld_y(ld_y),
    .start(start), .busy(busy), .X(X), .Y(Y), .DONE(DONE),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .score(score), .res_valid(res_valid), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int img_x[NP], img_y[NP];
  int arm_cyc = -1000, stream_end = -1000;
  bit cmp_en = 0, rv_expect = 0, rv_prev = 0;
  int exp_score = 0, exp_c[4], rv_cyc = 0;
  bit exp_to = 0;
  int mk;
  logic [3:0] mex, mey;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic bit in_rad(int px, int py, int cx, int cy);
    return (px - cx) * (px - cx) + (py - cy) * (py - cy) <= 16;
  endfunction

  function automatic int model_score(int ax, int ay, int bx, int by);
    int s = 0;
    for (int k = 0; k < NP; k++)
      if (in_rad(img_x[k], img_y[k], ax, ay) || in_rad(img_x[k], img_y[k], bx, by)) s++;
    return s;
  endfunction

  // Per-cycle compare: X/Y follow the image for the 40 cycles after the ARM edge, else 0;
  // every res_valid pulse must be expected and carry the model's results.
  always @(negedge CLK) if (cmp_en) begin
    mk = cyc - arm_cyc;
    if (cyc >= arm_cyc && cyc < stream_end && mk < NP) begin
      mex = 4'(img_x[mk]); mey = 4'(img_y[mk]);
    end else begin
      mex = '0; mey = '0;
    end
    chk("stream_x", 32'(X), 32'(mex));
    chk("stream_y", 32'(Y), 32'(mey));
    if (res_valid) begin
      if (!rv_expect) chk("unexpected_res_valid", 32'(res_valid), 0);
      else begin
        chk("score", 32'(score), exp_score);
        chk("timeout", 32'(timeout), 32'(exp_to));
        chk("res_c1x", 32'(res_c1x), exp_c[0]);
        chk("res_c1y", 32'(res_c1y), exp_c[1]);
        chk("res_c2x", 32'(res_c2x), exp_c[2]);
        chk("res_c2y", 32'(res_c2y), exp_c[3]);
        chk("busy_at_valid", 32'(busy), 1);
      end
      rv_expect = 0;
      rv_cyc = cyc;
    end else if (rv_prev) begin
      chk("busy_after_valid", 32'(busy), 0);
    end
    rv_prev = res_valid;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic load(input int a, input int x, input int y);
    ld_en = 1'b1; ld_addr = 6'(a); ld_x = 4'(x); ld_y = 4'(y);
    tick;
    ld_en = 1'b0;
    if (a < NP) begin img_x[a] = x; img_y[a] = y; end
  endtask

  task automatic load_random;
    for (int i = 0; i < NP; i++) load(i, $urandom_range(0, 15), $urandom_range(0, 15));
  endtask

  task automatic set_c_junk;
    C1X = 4'($urandom); C1Y = 4'($urandom); C2X = 4'($urandom); C2Y = 4'($urandom);
  endtask

  task automatic run(input int ax, input int ay, input int bx, input int by,
                     input int mode, input bit junk);
    int cap, n;
    cap = 0;
    start = 1'b1; tick; start = 1'b0;
    chk("busy_on_start", 32'(busy), 1);
    chk("timeout_cleared", 32'(timeout), 0);
    chk("score_cleared", 32'(score), 0);
    DONE = 1'b0;
    if (mode != M_HELD) repeat ($urandom_range(0, 3)) tick;
    DONE = 1'b1; arm_cyc = cyc + 1; stream_end = cyc + 1 + NP;
    tick;
    for (int i = 0; i < NP; i++) begin
      if (mode != M_HELD) DONE = 1'($urandom_range(0, 1));
      if (junk) begin
        start = 1'($urandom_range(0, 1)); ld_en = 1'b1;
        ld_addr = 6'($urandom_range(0, NP - 1)); ld_x = 4'($urandom); ld_y = 4'($urandom);
      end
      tick;
    end
    start = 1'b0; ld_en = 1'b0;
    exp_to = (mode == M_TO);
    exp_score = exp_to ? 0 : model_score(ax, ay, bx, by);
    exp_c[0] = exp_to ? 0 : ax; exp_c[1] = exp_to ? 0 : ay;
    exp_c[2] = exp_to ? 0 : bx; exp_c[3] = exp_to ? 0 : by;
    rv_expect = 1;
    set_c_junk;
    if (mode == M_HELD) begin DONE = 1'b1; repeat ($urandom_range(2, 6)) tick; end
    DONE = 1'b0;
    if (mode != M_TO) begin
      repeat ($urandom_range(1, 6)) tick;
      DONE = 1'b1; C1X = 4'(ax); C1Y = 4'(ay); C2X = 4'(bx); C2Y = 4'(by);
      cap = cyc + 1;
      tick;
      DONE = 1'($urandom_range(0, 1));
      set_c_junk;
    end
    n = 0;
    while (!res_valid && n < 5000) begin tick; n++; end
    chk("res_valid_seen", 32'(res_valid), 1);
    if (mode == M_TO) chk("timeout_latency", cyc - (arm_cyc + NP), TO_CYC);
    else chk("score_latency", cyc - cap, NP);
    tick;
    chk("busy_drop", 32'(busy), 0);
    DONE = 1'b0;
    repeat (2) tick;
    chk("score_hold", 32'(score), exp_score);
    chk("timeout_hold", 32'(timeout), 32'(exp_to));
    chk("res_c2y_hold", 32'(res_c2y), exp_c[3]);
  endtask

  task automatic abort_run;
    start = 1'b1; tick; start = 1'b0;
    DONE = 1'b1; arm_cyc = cyc + 1; stream_end = cyc + 1 + NP;
    tick;
    repeat (10) tick;
    RST = 1'b1; stream_end = cyc + 1;
    tick;
    RST = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_res_valid", 32'(res_valid), 0);
    chk("abort_score", 32'(score), 0);
    repeat (60) begin DONE = 1'($urandom_range(0, 1)); tick; end
    DONE = 1'b0;
    chk("abort_idle_busy", 32'(busy), 0);
  endtask

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, ax, ay, bx, by, s1;
    RST = 1'b1;
    repeat (3) tick;
    RST = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_x", 32'(X), 0);
    chk("rst_y", 32'(Y), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_res_c1x", 32'(res_c1x), 0);
    cmp_en = 1;

    for (int i = 0; i < NP; i++) load(i, 3, 3);
    chk("model_pin_all_33", model_score(3, 3, 12, 12), 40);
    run(3, 3, 12, 12, M_NORM, 0);

    for (int i = 0; i < NP; i++) load(i, (i % 2) ? 15 : 0, (i % 2) ? 15 : 0);
    chk("model_pin_corners", model_score(0, 0, 15, 15), 40);
    chk("model_pin_one_corner", model_score(0, 0, 0, 0), 20);
    run(0, 0, 15, 15, M_NORM, 0);
    run(0, 0, 0, 0, M_HELD, 0);

    for (int i = 0; i < NP; i++) load(i, 15, 0);
    load(0, 12, 8); load(1, 11, 11); load(2, 13, 8); load(3, 11, 12);
    chk("model_pin_radius", model_score(8, 8, 0, 15), 1);
    run(8, 8, 0, 15, M_NORM, 0);

    run(1, 2, 3, 4, M_TO, 0);
    run(8, 8, 0, 15, M_NORM, 0);

    load_random;
    k = $urandom_range(0, NP - 1);
    ax = img_x[k]; ay = img_y[k]; bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
    s1 = model_score(ax, ay, bx, by);
    run(ax, ay, bx, by, M_NORM, 1);
    run(ax, ay, bx, by, M_NORM, 0);
    chk("junk_same_score", 32'(score), s1);

    load(45, 7, 9);
    load(63, 1, 14);
    run(bx, by, ax, ay, M_HELD, 0);

    abort_run;
    run(ax, ay, bx, by, M_NORM, 0);

    repeat (3) begin
      load_random;
      k = $urandom_range(0, NP - 1);
      run(img_x[k], img_y[k], $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
